// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a
// saturating counter of inserted load-use bubbles.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic [4:0]        ID_Rd,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRt,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemtoReg,
  input  logic              ID_ALUSrc,
  input  logic [3:0]        ID_ALUOp,
  input  logic [DATA_W-1:0] ID_RegData1,
  input  logic [DATA_W-1:0] ID_RegData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic              Flush,
  input  logic              Hold,
  output logic [4:0]        ID_EX_Rs,
  output logic [4:0]        ID_EX_Rt,
  output logic [4:0]        ID_EX_Rd,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemtoReg,
  output logic              ID_EX_ALUSrc,
  output logic [3:0]        ID_EX_ALUOp,
  output logic [DATA_W-1:0] ID_EX_RegData1,
  output logic [DATA_W-1:0] ID_EX_RegData2,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic [DATA_W-1:0] ID_EX_PC4,
  output logic              LoadUse,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic [CNT_W-1:0]  StallCount
);

  // Register numbers plus control: everything a bubble must clear.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
  } data_t;

  ctrl_t            ctrl_d, ctrl_q, ctrl_id;
  data_t            data_d, data_q, data_id;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             rd_match;
  logic             load_use;

  always_comb begin
    ctrl_id = '{rs: ID_Rs, rt: ID_Rt, rd: ID_Rd, reg_write: ID_RegWrite,
                mem_read: ID_MemRead, mem_write: ID_MemWrite, mem_to_reg: ID_MemtoReg,
                alu_src: ID_ALUSrc, alu_op: ID_ALUOp};
    data_id = '{rd1: ID_RegData1, rd2: ID_RegData2, imm: ID_Imm, pc4: ID_PC4};
  end

  // A load into $0 never creates a dependency.
  assign rd_match = (ctrl_q.rd != 5'd0) &&
                    ((ID_UsesRs && (ctrl_q.rd == ID_Rs)) ||
                     (ID_UsesRt && (ctrl_q.rd == ID_Rt)));
  assign load_use = ctrl_q.mem_read && rd_match && !Flush && !Hold;

  assign LoadUse     = load_use;
  assign PC_Write    = ~(load_use | Hold);
  assign IF_ID_Write = ~(load_use | Hold);

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (Flush) begin
      ctrl_d = '0;
      data_d = data_id;
    end else if (Hold) begin
      ctrl_d = ctrl_q;
    end else if (load_use) begin
      ctrl_d = '0;
      data_d = data_id;
      cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      ctrl_d = ctrl_id;
      data_d = data_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ID_EX_Rs       = ctrl_q.rs;
  assign ID_EX_Rt       = ctrl_q.rt;
  assign ID_EX_Rd       = ctrl_q.rd;
  assign ID_EX_RegWrite = ctrl_q.reg_write;
  assign ID_EX_MemRead  = ctrl_q.mem_read;
  assign ID_EX_MemWrite = ctrl_q.mem_write;
  assign ID_EX_MemtoReg = ctrl_q.mem_to_reg;
  assign ID_EX_ALUSrc   = ctrl_q.alu_src;
  assign ID_EX_ALUOp    = ctrl_q.alu_op;
  assign ID_EX_RegData1 = data_q.rd1;
  assign ID_EX_RegData2 = data_q.rd2;
  assign ID_EX_Imm      = data_q.imm;
  assign ID_EX_PC4      = data_q.pc4;
  assign StallCount     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; a second instance with a 2-bit counter exercises
// counter saturation.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        uses_rs, uses_rt, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
  logic [3:0]  alu_op;
  logic [31:0] rd1, rd2, imm, pc4;
  logic        flush, hold;

  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_rw, ex_mr, ex_mw, ex_m2r, ex_as;
  logic [3:0]  ex_op;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic        load_use, pc_write, ifid_write;
  logic [15:0] stall_cnt;

  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_rw, s_mr, s_mw, s_m2r, s_as;
  logic [3:0]  s_op;
  logic [31:0] s_rd1, s_rd2, s_imm, s_pc4;
  logic        s_lu, s_pcw, s_ifw;
  logic [1:0]  s_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_Rd(id_rd),
    .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt), .ID_RegWrite(reg_write),
    .ID_MemRead(mem_read), .ID_MemWrite(mem_write), .ID_MemtoReg(mem_to_reg),
    .ID_ALUSrc(alu_src), .ID_ALUOp(alu_op), .ID_RegData1(rd1), .ID_RegData2(rd2),
    .ID_Imm(imm), .ID_PC4(pc4), .Flush(flush), .Hold(hold),
    .ID_EX_Rs(ex_rs), .ID_EX_Rt(ex_rt), .ID_EX_Rd(ex_rd), .ID_EX_RegWrite(ex_rw),
    .ID_EX_MemRead(ex_mr), .ID_EX_MemWrite(ex_mw), .ID_EX_MemtoReg(ex_m2r),
    .ID_EX_ALUSrc(ex_as), .ID_EX_ALUOp(ex_op), .ID_EX_RegData1(ex_rd1),
    .ID_EX_RegData2(ex_rd2), .ID_EX_Imm(ex_imm), .ID_EX_PC4(ex_pc4),
    .LoadUse(load_use), .PC_Write(pc_write), .IF_ID_Write(ifid_write),
    .StallCount(stall_cnt)
  );

  id_ex_stage_reg #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_Rd(id_rd),
    .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt), .ID_RegWrite(reg_write),
    .ID_MemRead(mem_read), .ID_MemWrite(mem_write), .ID_MemtoReg(mem_to_reg),
    .ID_ALUSrc(alu_src), .ID_ALUOp(alu_op), .ID_RegData1(rd1), .ID_RegData2(rd2),
    .ID_Imm(imm), .ID_PC4(pc4), .Flush(flush), .Hold(hold),
    .ID_EX_Rs(s_rs), .ID_EX_Rt(s_rt), .ID_EX_Rd(s_rd), .ID_EX_RegWrite(s_rw),
    .ID_EX_MemRead(s_mr), .ID_EX_MemWrite(s_mw), .ID_EX_MemtoReg(s_m2r),
    .ID_EX_ALUSrc(s_as), .ID_EX_ALUOp(s_op), .ID_EX_RegData1(s_rd1),
    .ID_EX_RegData2(s_rd2), .ID_EX_Imm(s_imm), .ID_EX_PC4(s_pc4),
    .LoadUse(s_lu), .PC_Write(s_pcw), .IF_ID_Write(s_ifw), .StallCount(s_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic urs, input logic urt, input logic rw, input logic mr,
                       input logic [31:0] d1);
    id_rs = rs; id_rt = rt; id_rd = rd; uses_rs = urs; uses_rt = urt;
    reg_write = rw; mem_read = mr; mem_write = 1'b0; mem_to_reg = mr; alu_src = mr;
    alu_op = 4'h2; rd1 = d1; rd2 = ~d1; imm = 32'h10; pc4 = 32'h400;
    #1;
  endtask

  task automatic test_reset();
    flush = 1'b0; hold = 1'b0; reset = 1'b0;
    drive(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    step(); step();
    vectors++;
    if ({ex_rs, ex_rt, ex_rd, ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_op} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rs=%0d rt=%0d rd=%0d rw=%b mr=%b op=%h, want all 0",
               ex_rs, ex_rt, ex_rd, ex_rw, ex_mr, ex_op);
    end
    vectors++;
    if ({ex_rd1, ex_rd2, ex_imm, ex_pc4} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h %h, want 0", ex_rd1, ex_rd2, ex_imm, ex_pc4);
    end
    vectors++;
    if (stall_cnt !== 16'd0 || pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_misc: got cnt=%0d pcw=%b ifw=%b, want 0 1 1",
               stall_cnt, pc_write, ifid_write);
    end
    reset = 1'b1;
  endtask

  task automatic test_pass();
    drive(5'd3, 5'd9, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
    step();
    vectors++;
    if (ex_rs !== 5'd3 || ex_rd1 !== 32'h1234_5678 || ex_rw !== 1'b1 || ex_rd !== 5'd7 ||
        ex_rd2 !== 32'hEDCB_A987 || ex_op !== 4'h2 || ex_pc4 !== 32'h400) begin
      miscompares++;
      $display("FAIL pass: got rs=%0d d1=%h rw=%b rd=%0d d2=%h op=%h pc4=%h, want 3 12345678 1 7 edcba987 2 400",
               ex_rs, ex_rd1, ex_rw, ex_rd, ex_rd2, ex_op, ex_pc4);
    end
  endtask

  task automatic test_load_use();
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    drive(5'd5, 5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'hAAAA_0001);
    vectors++;
    if (load_use !== 1'b1 || pc_write !== 1'b0 || ifid_write !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_detect: got lu=%b pcw=%b ifw=%b, want 1 0 0",
               load_use, pc_write, ifid_write);
    end
    step();
    vectors++;
    if (ex_rw !== 1'b0 || ex_rd !== 5'd0 || ex_mr !== 1'b0 || stall_cnt !== 16'd1 ||
        load_use !== 1'b0 || pc_write !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_bubble: got rw=%b rd=%0d mr=%b cnt=%0d lu=%b pcw=%b, want 0 0 0 1 0 1",
               ex_rw, ex_rd, ex_mr, stall_cnt, load_use, pc_write);
    end
    step();
    vectors++;
    if (ex_rd !== 5'd8 || ex_rw !== 1'b1 || ex_rs !== 5'd5 || stall_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL lu_proceed: got rd=%0d rw=%b rs=%0d cnt=%0d, want 8 1 5 1",
               ex_rd, ex_rw, ex_rs, stall_cnt);
    end
  endtask

  task automatic test_no_stall();
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    drive(5'd2, 5'd5, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (load_use !== 1'b0 || pc_write !== 1'b1) begin
      miscompares++;
      $display("FAIL nostall_rt_unused: got lu=%b pcw=%b, want 0 1", load_use, pc_write);
    end
    step();
    drive(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    vectors++;
    if (ex_rd !== 5'd10 || stall_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL nostall_pass: got rd=%0d cnt=%0d, want 10 1", ex_rd, stall_cnt);
    end
    step();
    drive(5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (load_use !== 1'b0 || pc_write !== 1'b1) begin
      miscompares++;
      $display("FAIL nostall_r0: got lu=%b pcw=%b, want 0 1", load_use, pc_write);
    end
    step();
    vectors++;
    if (ex_rd !== 5'd11 || stall_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL nostall_r0_pass: got rd=%0d cnt=%0d, want 11 1", ex_rd, stall_cnt);
    end
  endtask

  task automatic test_flush_hold();
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    flush = 1'b1;
    drive(5'd5, 5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (load_use !== 1'b0 || pc_write !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_gate: got lu=%b pcw=%b, want 0 1", load_use, pc_write);
    end
    step();
    flush = 1'b0;
    vectors++;
    if (ex_rw !== 1'b0 || ex_rd !== 5'd0 || ex_mr !== 1'b0 || ex_rs !== 5'd0 ||
        stall_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL flush_bubble: got rw=%b rd=%0d mr=%b rs=%0d cnt=%0d, want 0 0 0 0 1",
               ex_rw, ex_rd, ex_mr, ex_rs, stall_cnt);
    end
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    hold = 1'b1;
    drive(5'd5, 5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (load_use !== 1'b0 || pc_write !== 1'b0 || ifid_write !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_gate: got lu=%b pcw=%b ifw=%b, want 0 0 0",
               load_use, pc_write, ifid_write);
    end
    step();
    hold = 1'b0;
    #1;
    vectors++;
    if (ex_rd !== 5'd5 || ex_mr !== 1'b1 || ex_rs !== 5'd1 || stall_cnt !== 16'd1 ||
        load_use !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_keep: got rd=%0d mr=%b rs=%0d cnt=%0d lu=%b, want 5 1 1 1 1",
               ex_rd, ex_mr, ex_rs, stall_cnt, load_use);
    end
    step();
    vectors++;
    if (ex_rd !== 5'd0 || stall_cnt !== 16'd2 || s_cnt !== 2'd2) begin
      miscompares++;
      $display("FAIL hold_release: got rd=%0d cnt=%0d sat_cnt=%0d, want 0 2 2",
               ex_rd, stall_cnt, s_cnt);
    end
    step();
  endtask

  task automatic test_saturation();
    logic [15:0] exp_cnt;
    logic [1:0]  exp_sat;
    exp_cnt = 16'd2;
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
      step();
      drive(5'd5, 5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step();
      exp_cnt = exp_cnt + 16'd1;
      exp_sat = 2'd3;
      vectors++;
      if (stall_cnt !== exp_cnt || s_cnt !== exp_sat) begin
        miscompares++;
        $display("FAIL saturate[%0d]: got cnt=%0d sat_cnt=%0d, want %0d %0d",
                 i, stall_cnt, s_cnt, exp_cnt, exp_sat);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    drive(5'd5, 5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    vectors++;
    if (ex_rd !== 5'd0 || ex_mr !== 1'b0 || stall_cnt !== 16'd0 || s_cnt !== 2'd0 ||
        pc_write !== 1'b1 || ifid_write !== 1'b1 || load_use !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got rd=%0d mr=%b cnt=%0d sat=%0d pcw=%b ifw=%b lu=%b, want 0 0 0 0 1 1 0",
               ex_rd, ex_mr, stall_cnt, s_cnt, pc_write, ifid_write, load_use);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_load_use();
    test_no_stall();
    test_flush_hold();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage core, with integrated load-use hazard detection.
- Captures decoded control, register operands and immediate from ID each cycle.
- Drives the ID_EX_* fields consumed by the EX stage and the EX forwarding unit (notably ID_EX_Rs).
- Inserts a one-cycle bubble and freezes PC/IF_ID on a load-use hazard; also a 16-bit saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, width of operand, immediate and PC+4 fields.
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- ID_Rs, ID_Rt  input  5 each  source register numbers of the instruction in ID.
- ID_Rd  input  5  destination register, already muxed (rt/rd/31).
- ID_UsesRs, ID_UsesRt  input  1 each  instruction actually reads Rs / Rt.
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc  input  1 each  decoded control.
- ID_ALUOp  input  4  ALU operation.
- ID_RegData1, ID_RegData2  input  DATA_W  register file read data.
- ID_Imm  input  DATA_W  extended immediate.
- ID_PC4  input  DATA_W  PC+4 of the ID instruction.
- Flush  input  1  squash the ID instruction (branch/jump taken in EX).
- Hold  input  1  global pipeline freeze (memory wait).
- ID_EX_* outputs  output  same widths as the matching ID_* inputs  registered copies: Rs, Rt, Rd, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp, RegData1, RegData2, Imm, PC4.
- LoadUse  output  1  combinational hazard flag.
- PC_Write, IF_ID_Write  output  1 each  low = freeze PC / IF_ID.
- StallCount  output  CNT_W  saturating count of inserted load-use bubbles.

Behaviour:
- Hazard detection (combinational):
  - LoadUse = ID_EX_MemRead && ID_EX_Rd!=0 && ((ID_UsesRs && ID_EX_Rd==ID_Rs) || (ID_UsesRt && ID_EX_Rd==ID_Rt)).
  - LoadUse is gated to 0 when Flush=1 or Hold=1.
- Freeze outputs: PC_Write = IF_ID_Write = ~(LoadUse | Hold).
- Register update at posedge, priority top-down:
  - reset==0: all ID_EX_* = 0; StallCount = 0.
  - Flush: load bubble, i.e. all control fields 0 (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp=0) and Rs/Rt/Rd = 0; data fields may take ID values.
  - Hold: all ID_EX_* keep their value; StallCount unchanged.
  - LoadUse: load bubble as above; StallCount += 1, saturating at all-ones.
  - Otherwise: ID_EX_* <= ID_*.
- Latency: one cycle ID to ID_EX_*.
- A bubble has Rd=0 and RegWrite=0, so it never matches forwarding or the next hazard check. The stalled instruction re-presents next cycle, finds no hazard, and proceeds: exactly one bubble per load-use.
- Flush and LoadUse in the same cycle: Flush wins, no freeze, counter unchanged.
- Reset mid-stall: all outputs 0 next cycle; PC_Write = IF_ID_Write = 1 once reset deasserts (LoadUse depends only on the now-zero ID_EX_MemRead).
- Load into $0 (ID_EX_Rd=0): never a hazard.

Test Plan:
- Reset held low 2 cycles with nonzero inputs -> all ID_EX_*=0, StallCount=0, PC_Write=1.
- Normal pass: ID_Rs=3, ID_RegData1=0x1234_5678, RegWrite=1 -> next cycle ID_EX_Rs=3, ID_EX_RegData1=0x12345678, ID_EX_RegWrite=1.
- lw $5 followed by add using $5 as Rs -> LoadUse=1, PC_Write=IF_ID_Write=0 for 1 cycle; bubble in ID_EX (RegWrite=0, Rd=0); add enters next cycle; StallCount=1.
- lw $5 followed by instruction with ID_Rt=5 but ID_UsesRt=0, or lw $0 followed by a user of $0 -> no stall, StallCount unchanged.
- Load-use coincident with Flush=1 -> bubble loaded, PC_Write=1, StallCount unchanged; same case with Hold=1 -> ID_EX_* unchanged, PC_Write=0, no count.
- Force StallCount to 0xFFFE, trigger 3 load-use stalls -> StallCount ends at 0xFFFF.
